// File: rtl/tile_addr_if.sv
// Address beat stream from the tile sequencer to the operand buffer read ports.
interface tile_addr_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  addr_valid;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_sel;
  logic                  addr_last;

  modport master (
    output addr_valid, addr, addr_sel, addr_last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, addr, addr_sel, addr_last,
    output addr_ready
  );
endinterface

// File: rtl/tile_address_sequencer.sv
// Latches one tile per start pulse and streams its A then B operand element
// addresses, column fastest, followed by a one-cycle tile acknowledge.
module tile_address_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  output logic                  o_tile_req_c,
  output logic                  o_agu_ready_c,
  input  logic                  i_start_tile,
  input  logic [IDX_WIDTH-1:0]  i_i_tile,
  input  logic [IDX_WIDTH-1:0]  i_j_tile,
  input  logic [IDX_WIDTH-1:0]  i_k_tile,
  input  logic [IDX_WIDTH-1:0]  i_etm,
  input  logic [IDX_WIDTH-1:0]  i_etn,
  input  logic [IDX_WIDTH-1:0]  i_etk,
  input  logic [IDX_WIDTH-1:0]  i_k_pitch,
  input  logic [IDX_WIDTH-1:0]  i_n_pitch,
  input  logic [ADDR_WIDTH-1:0] i_base_a,
  input  logic [ADDR_WIDTH-1:0] i_base_b,
  tile_addr_if.master           m_addr,
  output logic                  o_tile_ack
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN_A, S_GEN_B, S_ACK} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]  r_i, r_j, r_k, r_etm, r_etn, r_etk, r_kp, r_np;
  logic [IDX_WIDTH-1:0]  w_i_nxt, w_j_nxt, w_k_nxt, w_etm_nxt, w_etn_nxt, w_etk_nxt, w_kp_nxt, w_np_nxt;
  logic [ADDR_WIDTH-1:0] r_base_a, r_base_b, w_base_a_nxt, w_base_b_nxt;
  logic [ADDR_WIDTH-1:0] r_row_b, w_row_b_nxt, r_ptr, w_ptr_nxt, r_addr, w_addr_nxt;
  logic [IDX_WIDTH-1:0]  r_row, w_row_nxt, r_col, w_col_nxt;
  logic                  r_valid, w_valid_nxt, r_sel, w_sel_nxt, r_last, w_last_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_row_a, w_row_b;
  logic                  w_a_nz, w_b_nz;

  // Tile origin addresses; products are formed at full address width and wrap.
  assign w_row_a = r_base_a + ADDR_WIDTH'(r_i) * ADDR_WIDTH'(r_kp) + ADDR_WIDTH'(r_k);
  assign w_row_b = r_base_b + ADDR_WIDTH'(r_k) * ADDR_WIDTH'(r_np) + ADDR_WIDTH'(r_j);
  assign w_a_nz  = (r_etm != '0) && (r_etk != '0);
  assign w_b_nz  = (r_etk != '0) && (r_etn != '0);
  assign w_xfer  = r_valid && m_addr.addr_ready;

  assign o_agu_ready_c     = (r_state == S_IDLE);
  assign o_tile_req_c      = i_en && o_agu_ready_c;
  assign m_addr.addr_valid = r_valid;
  assign m_addr.addr       = r_addr;
  assign m_addr.addr_sel   = r_sel;
  assign m_addr.addr_last  = r_last;
  assign o_tile_ack        = r_ack;

  // Next-state, datapath and output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_i_nxt      = r_i;
    w_j_nxt      = r_j;
    w_k_nxt      = r_k;
    w_etm_nxt    = r_etm;
    w_etn_nxt    = r_etn;
    w_etk_nxt    = r_etk;
    w_kp_nxt     = r_kp;
    w_np_nxt     = r_np;
    w_base_a_nxt = r_base_a;
    w_base_b_nxt = r_base_b;
    w_row_b_nxt  = r_row_b;
    w_ptr_nxt    = r_ptr;
    w_addr_nxt   = r_addr;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_valid_nxt  = r_valid;
    w_sel_nxt    = r_sel;
    w_last_nxt   = 1'b0;
    w_ack_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_start_tile) begin
          w_i_nxt      = i_i_tile;
          w_j_nxt      = i_j_tile;
          w_k_nxt      = i_k_tile;
          w_etm_nxt    = i_etm;
          w_etn_nxt    = i_etn;
          w_etk_nxt    = i_etk;
          w_kp_nxt     = i_k_pitch;
          w_np_nxt     = i_n_pitch;
          w_base_a_nxt = i_base_a;
          w_base_b_nxt = i_base_b;
          w_state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_row_nxt   = '0;
        w_col_nxt   = '0;
        w_row_b_nxt = w_row_b;
        if (w_a_nz) begin
          w_state_nxt = S_GEN_A;
          w_ptr_nxt   = w_row_a;
          w_addr_nxt  = w_row_a;
          w_valid_nxt = 1'b1;
          w_sel_nxt   = 1'b0;
        end else if (w_b_nz) begin
          w_state_nxt = S_GEN_B;
          w_ptr_nxt   = w_row_b;
          w_addr_nxt  = w_row_b;
          w_valid_nxt = 1'b1;
          w_sel_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_ACK;
          w_ack_nxt   = 1'b1;
        end
      end
      S_GEN_A: begin
        if (w_xfer) begin
          if (r_col == r_etk - IDX_WIDTH'(1)) begin
            if (r_row == r_etm - IDX_WIDTH'(1)) begin
              if (r_etn != '0) begin
                w_state_nxt = S_GEN_B;
                w_ptr_nxt   = r_row_b;
                w_addr_nxt  = r_row_b;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
                w_sel_nxt   = 1'b1;
              end else begin
                w_state_nxt = S_ACK;
                w_valid_nxt = 1'b0;
                w_ack_nxt   = 1'b1;
              end
            end else begin
              w_row_nxt  = r_row + IDX_WIDTH'(1);
              w_col_nxt  = '0;
              w_ptr_nxt  = r_ptr + ADDR_WIDTH'(r_kp);
              w_addr_nxt = r_ptr + ADDR_WIDTH'(r_kp);
            end
          end else begin
            w_col_nxt  = r_col + IDX_WIDTH'(1);
            w_addr_nxt = r_addr + ADDR_WIDTH'(1);
          end
        end
      end
      S_GEN_B: begin
        if (w_xfer) begin
          if (r_col == r_etn - IDX_WIDTH'(1)) begin
            if (r_row == r_etk - IDX_WIDTH'(1)) begin
              w_state_nxt = S_ACK;
              w_valid_nxt = 1'b0;
              w_ack_nxt   = 1'b1;
            end else begin
              w_row_nxt  = r_row + IDX_WIDTH'(1);
              w_col_nxt  = '0;
              w_ptr_nxt  = r_ptr + ADDR_WIDTH'(r_np);
              w_addr_nxt = r_ptr + ADDR_WIDTH'(r_np);
            end
          end else begin
            w_col_nxt  = r_col + IDX_WIDTH'(1);
            w_addr_nxt = r_addr + ADDR_WIDTH'(1);
          end
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Last flag tracks the beat that will be presented next; A is final only when B is empty.
    if (w_state_nxt == S_GEN_A) begin
      w_last_nxt = (w_row_nxt == w_etm_nxt - IDX_WIDTH'(1)) &&
                   (w_col_nxt == w_etk_nxt - IDX_WIDTH'(1)) && (w_etn_nxt == '0);
    end else if (w_state_nxt == S_GEN_B) begin
      w_last_nxt = (w_row_nxt == w_etk_nxt - IDX_WIDTH'(1)) &&
                   (w_col_nxt == w_etn_nxt - IDX_WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_etm    <= '0;
      r_etn    <= '0;
      r_etk    <= '0;
      r_kp     <= '0;
      r_np     <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_row_b  <= '0;
      r_ptr    <= '0;
      r_addr   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_valid  <= 1'b0;
      r_sel    <= 1'b0;
      r_last   <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      r_k      <= w_k_nxt;
      r_etm    <= w_etm_nxt;
      r_etn    <= w_etn_nxt;
      r_etk    <= w_etk_nxt;
      r_kp     <= w_kp_nxt;
      r_np     <= w_np_nxt;
      r_base_a <= w_base_a_nxt;
      r_base_b <= w_base_b_nxt;
      r_row_b  <= w_row_b_nxt;
      r_ptr    <= w_ptr_nxt;
      r_addr   <= w_addr_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_valid  <= w_valid_nxt;
      r_sel    <= w_sel_nxt;
      r_last   <= w_last_nxt;
      r_ack    <= w_ack_nxt;
    end
  end

endmodule

// File: doc/tile_address_sequencer.md
# tile_address_sequencer

Consumer end of the tile handshake driven by the convolution/matmul tile-indices generator. It accepts one tile per `start_tile` pulse and latches the tile origin and effective sizes. It streams the operand element addresses for that tile: A tile first, then B tile, over a valid/ready interface to the buffer read ports. It then returns a one-cycle `tile_ack`, and advertises `AGU_ready`/`tile_req` while idle.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `IDX_WIDTH`, 16, index/dimension width.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  sequencer enabled; gates `tile_req`.
- `tile_req`  out  1  `en && AGU_ready`.
- `AGU_ready`  out  1  high only in IDLE.
- `start_tile`  in  1  one-cycle tile start; sampled only in IDLE.
- `i_tile`, `j_tile`, `k_tile`  in  IDX_WIDTH each  tile origin (row of A, column of B, reduction offset).
- `eTM`, `eTN`, `eTK`  in  IDX_WIDTH each  effective tile sizes.
- `K`, `N`  in  IDX_WIDTH each  row pitch of A (K) and B (N).
- `base_A`, `base_B`  in  ADDR_WIDTH each  operand base addresses.
- `addr_valid`  out  1  address beat valid.
- `addr_ready`  in  1  downstream accepts beat.
- `addr`  out  ADDR_WIDTH  element address.
- `addr_sel`  out  1  0 = A beat, 1 = B beat.
- `addr_last`  out  1  final beat of the tile.
- `tile_ack`  out  1  one-cycle pulse: tile address stream complete.

## Operation
- FSM states: IDLE, LOAD, GEN_A, GEN_B, ACK.
- **IDLE**
  - `start_tile` latches all tile inputs and bases, then goes to LOAD.
  - `start_tile` in any other state is ignored.
- **LOAD**
  - Computes `rowA = base_A + i_tile*K + k_tile` and `rowB = base_B + k_tile*N + j_tile`.
  - Clears row/col counters.
  - Next state is GEN_A if `eTM!=0 && eTK!=0`, else GEN_B if `eTK!=0 && eTN!=0`, else ACK.
- **GEN_A**
  - Beats are A(r,c) = `rowA + r*K + c`, for r in 0..eTM-1 and c in 0..eTK-1, column fastest.
  - Row advance adds K to the row pointer (incremental; no per-beat multiply).
  - After the last A beat, goes to GEN_B if `eTN!=0`, else ACK.
- **GEN_B**
  - Beats are B(r,c) = `rowB + r*N + c`, for r in 0..eTK-1 and c in 0..eTN-1, column fastest.
  - After the last beat, goes to ACK.
- **Beat transfer and last flag**
  - A beat transfers on `addr_valid && addr_ready`.
  - `addr_last` is high on the globally final beat only: the last B beat, or the last A beat when B is skipped.
- **ACK**
  - `tile_ack` is 1 for exactly one cycle, then the FSM returns to IDLE.
  - Latched indices are retained until the next `start_tile`.
- **Arithmetic**
  - All address arithmetic is modulo 2^ADDR_WIDTH (wrap, no saturation).
  - Products are formed at ADDR_WIDTH after zero-extension.

## Timing
- Reset values: `addr_valid`=0, `addr_last`=0, `addr_sel`=0, `addr`=0, `tile_ack`=0, state IDLE.
  - So `AGU_ready`=1, and `tile_req`=`en`.
- Latency:
  - `start_tile` at cycle T: LOAD at T+1, first `addr_valid` at T+2.
  - Final handshake at cycle F: `tile_ack` at F+1, `AGU_ready` at F+2.
  - Zero-beat tile: `tile_ack` at T+2.
- Throughput: one beat per cycle while `addr_ready`=1.
- Backpressure: while `addr_valid && !addr_ready`, the values of `addr`, `addr_sel` and `addr_last` are held stable.
- `addr_valid` never deasserts without a handshake, except on `rst`.
- `AGU_ready` and `tile_req` are combinational from state and `en`; both are 0 in LOAD, GEN_A, GEN_B and ACK.
- Reset mid-stream: on the clock edge with `rst`=1, the FSM goes to IDLE and `addr_valid` drops.
  - No `tile_ack` is issued for the aborted tile.
- `start_tile` coincident with `rst`: reset wins; the tile is not latched.
- `en` low does not stop a tile in progress; it only masks `tile_req`.

## Test plan
- **Basic tile.** Inputs: i=4, j=0, k=2, eTM=2, eTK=3, eTN=2, K=8, N=4, base_A=0x1000, base_B=0x2000, `addr_ready`=1.
  - A beats: 0x1022, 0x1023, 0x1024, 0x102A, 0x102B, 0x102C.
  - B beats: 0x2008, 0x2009, 0x200C, 0x200D, 0x2010, 0x2011, with `addr_last` on 0x2011.
  - `tile_ack` one cycle later; 12 beats in 12 consecutive cycles.
- **Backpressure.** Same tile with `addr_ready` toggling 1,0,0,1,…
  - Identical address sequence; `addr` stable during every stall.
  - `tile_ack` exactly once.
- **Skipped B.** eTN=0, eTM=1, eTK=2, K=8, base_A=0, other indices 0.
  - Beats 0x0, 0x1, with `addr_last` on 0x1.
  - No B beats; then `tile_ack`.
- **Zero-beat tile.** eTK=0.
  - No `addr_valid`; `tile_ack` two cycles after `start_tile`.
- **Reset mid-stream.** Assert `rst` during GEN_A.
  - Next cycle: `addr_valid`=0, `AGU_ready`=1, no `tile_ack`.
  - A new tile afterwards starts from its first address.
- **Ignored start and wrap.** Pulse `start_tile` during GEN_B: ignored, current stream unchanged.
  - With base_B=0xFFFFFFFE, N=4, eTK=1, eTN=3, j=k=0: beats 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
